// File: rtl/pulse_gen.sv
// Register-mapped pulse/PWM source: programmable period, high width and burst count,
// with continuous mode and busy/done/cfg_err status. Drives the gate stage gen_in.
module pulse_gen #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 8'h10,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  we,
  input  logic                  init,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  gen_out,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2, DONE = 2'd3} state_t;

  state_t                  state_r;
  logic [CNT_WIDTH-1:0]    per_r, wid_r, sh_per_r, sh_wid_r, cnt_r;
  logic [7:0]              burst_r, sh_burst_r, pulses_r;
  logic                    sh_cont_r, done_r, cfg_err_r;

  logic [DATA_WIDTH-1:0]   off_s;
  logic [DATA_WIDTH-1:0]   rd_s;
  logic                    ctrl_wr_s, start_s, stop_s;
  logic [7:0]              burst_eff_s;
  logic                    more_s;

  // A configuration is unusable when there is no high phase or no low phase.
  function automatic logic cfg_bad(input logic [CNT_WIDTH-1:0] w, input logic [CNT_WIDTH-1:0] p);
    return (w == CNT_WIDTH'(0)) || (w >= p);
  endfunction

  assign off_s     = addr - BASE_ADDR;
  assign ctrl_wr_s = we && (off_s == 8'd0);
  assign start_s   = ctrl_wr_s && data_in[0];
  assign stop_s    = ctrl_wr_s && data_in[1];

  // Burst bookkeeping: a zero burst count means a single pulse.
  always_comb begin
    burst_eff_s = sh_burst_r;
    if (sh_burst_r == 8'd0) begin
      burst_eff_s = 8'd1;
    end else begin
      burst_eff_s = sh_burst_r;
    end
    more_s = ({1'b0, pulses_r} + 9'd1) < {1'b0, burst_eff_s};
  end

  // Read mux over the live register file.
  always_comb begin
    rd_s = 8'd0;
    case (off_s)
      8'd1:    rd_s = per_r[7:0];
      8'd2:    rd_s = per_r[15:8];
      8'd3:    rd_s = wid_r[7:0];
      8'd4:    rd_s = wid_r[15:8];
      8'd5:    rd_s = burst_r;
      8'd6:    rd_s = {5'd0, cfg_err_r, done_r, busy};
      default: rd_s = 8'd0;
    endcase
  end

  // Registered read data.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      data_out <= 8'd0;
    end else if (init) begin
      data_out <= 8'd0;
    end else begin
      data_out <= rd_s;
    end
  end

  // Live registers, shadow configuration and the pulse FSM.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_r <= IDLE;   per_r <= '0;       wid_r <= '0;     burst_r <= 8'd0;
      sh_per_r <= '0;    sh_wid_r <= '0;    sh_burst_r <= 8'd0; sh_cont_r <= 1'b0;
      cnt_r <= '0;       pulses_r <= 8'd0;  done_r <= 1'b0;  cfg_err_r <= 1'b0;
      gen_out <= 1'b0;   busy <= 1'b0;
    end else if (init) begin
      state_r <= IDLE;   per_r <= '0;       wid_r <= '0;     burst_r <= 8'd0;
      sh_per_r <= '0;    sh_wid_r <= '0;    sh_burst_r <= 8'd0; sh_cont_r <= 1'b0;
      cnt_r <= '0;       pulses_r <= 8'd0;  done_r <= 1'b0;  cfg_err_r <= 1'b0;
      gen_out <= 1'b0;   busy <= 1'b0;
    end else begin
      if (we) begin
        case (off_s)
          8'd1:    per_r[7:0]  <= data_in;
          8'd2:    per_r[15:8] <= data_in;
          8'd3:    wid_r[7:0]  <= data_in;
          8'd4:    wid_r[15:8] <= data_in;
          8'd5:    burst_r     <= data_in;
          default: ;
        endcase
      end
      case (state_r)
        IDLE: begin
          if (stop_s) begin
            state_r <= IDLE;
          end else if (start_s) begin
            done_r <= 1'b0;
            if (cfg_bad(wid_r, per_r)) begin
              cfg_err_r <= 1'b1;
            end else begin
              cfg_err_r  <= 1'b0;
              sh_per_r   <= per_r;
              sh_wid_r   <= wid_r;
              sh_burst_r <= burst_r;
              sh_cont_r  <= data_in[2];
              cnt_r      <= CNT_WIDTH'(1);
              pulses_r   <= 8'd0;
              state_r    <= HIGH;
              gen_out    <= 1'b1;
              busy       <= 1'b1;
            end
          end
        end
        HIGH: begin
          if (stop_s) begin
            state_r <= IDLE; gen_out <= 1'b0; busy <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_WIDTH'(1);
            if (cnt_r == sh_wid_r) begin
              state_r <= LOW;
              gen_out <= 1'b0;
            end
          end
        end
        LOW: begin
          if (stop_s) begin
            state_r <= IDLE; gen_out <= 1'b0; busy <= 1'b0;
          end else if (cnt_r == sh_per_r) begin
            pulses_r <= pulses_r + 8'd1;
            if (sh_cont_r || more_s) begin
              // Period boundary: pick up any timing written during the last period.
              sh_per_r <= per_r;
              sh_wid_r <= wid_r;
              if (cfg_bad(wid_r, per_r)) begin
                cfg_err_r <= 1'b1;
                state_r   <= IDLE;
                busy      <= 1'b0;
              end else begin
                cnt_r   <= CNT_WIDTH'(1);
                state_r <= HIGH;
                gen_out <= 1'b1;
              end
            end else begin
              state_r <= DONE;
              busy    <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + CNT_WIDTH'(1);
          end
        end
        DONE: begin
          if (!stop_s) begin
            done_r <= 1'b1;
          end
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE; gen_out <= 1'b0; busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pulse_gen.md
Name: pulse_gen

Overview:
- Register-mapped pulse/PWM source that produces the `gen_out` stream consumed by the channel gate stage's `gen_in`.
- Sits on the same 8-bit addr/data_in/data_out/we register bus.
- Generates bursts or continuous trains of pulses with programmable period and high width.
- Reports busy/done/error status.

Parameters:
DATA_WIDTH, 8, register bus data and address width
BASE_ADDR, 8'h10, address of register 0; block decodes BASE_ADDR..BASE_ADDR+6
CNT_WIDTH, 16, width of period/width counters (fixed to 2 bus bytes)

Ports:
clk  in  1  system clock, all logic on rising edge
res  in  1  asynchronous, active-low reset
addr  in  DATA_WIDTH  register address
data_in  in  DATA_WIDTH  write data
we  in  1  write strobe, one write per cycle
init  in  1  synchronous clear of all registers (same effect as reset)
data_out  out  DATA_WIDTH  registered read data
gen_out  out  1  pulse train to gate stage gen_in
busy  out  1  high while in HIGH or LOW state

Behaviour:
- Register map (offset from BASE_ADDR):
  - +0 CTRL: write-only strobes; bit0 START, bit1 STOP, bit2 CONT (continuous mode); reads 0.
  - +1 PER_L, +2 PER_H: period in clk cycles.
  - +3 WID_L, +4 WID_H: high width in clk cycles.
  - +5 BURST: number of pulses; 0 is treated as 1 unless CONT.
  - +6 STATUS (read-only): bit0 busy, bit1 done, bit2 cfg_err; bits cleared on START.
- Reset (res low, asynchronous) or init (synchronous):
  - All registers 0, state IDLE, gen_out=0, busy=0, data_out=0, counters 0.
- Read path: data_out <= register[addr] one cycle after addr presented. Unmapped addresses give 0. Writes to STATUS are ignored.
- FSM states IDLE, HIGH, LOW, DONE.
- IDLE:
  - START written at edge N:
    - If WID==0 or WID>=PER: set cfg_err, stay IDLE, gen_out stays 0.
    - Otherwise:
      - Latch PER, WID, BURST, CONT into shadow registers.
      - Load cnt=1 and pulses=0.
      - Enter HIGH; gen_out=1 from edge N+1.
- HIGH:
  - gen_out=1 for exactly WID cycles.
  - When cnt==WID: go to LOW, gen_out=0 next edge. cnt keeps counting.
- LOW:
  - gen_out=0 until cnt==PER.
  - At period end, pulses increments:
    - If CONT, or pulses+1 < BURST: reload shadows from live registers, cnt=1, go to HIGH.
    - Else go to DONE.
- DONE: one cycle, sets done=1, busy=0, then IDLE.
- Period/width arithmetic: total period = PER cycles, high = WID cycles, low = PER-WID cycles. Counter is CNT_WIDTH bits and never wraps, because PER <= 65535 bounds it.
- Register writes while busy affect the live registers only; they take effect at the next period boundary via shadow reload. Mid-pulse timing never changes.
- If a reloaded config is invalid (WID==0 or WID>=PER): set cfg_err, go to IDLE, gen_out=0.
- STOP: from any state, go to IDLE on next edge, gen_out=0, busy=0, done not set.
- START while busy: ignored.
- START and STOP in the same write: STOP wins.
- Reset mid-pulse: gen_out drops immediately (asynchronous); no glitch on release.
- busy equals (state==HIGH || state==LOW), registered.

Test Plan:
1. Reset → program PER=10, WID=3, BURST=2, write CTRL=0x01 → gen_out high 3 cycles, low 7, high 3, low 7. STATUS reads 0x02 after DONE, busy=0.
2. PER=5, WID=5, START → no pulses; STATUS=0x04. Then WID=2, START → cfg_err clears and pulses begin.
3. CONT mode, PER=8, WID=4, START; after 20 cycles write WID_L=6 → current pulse keeps width 4. From the next period boundary, high=6, low=2.
4. CONT running, write CTRL=0x03 (START+STOP) → gen_out 0 and busy 0 on next edge, done=0.
5. Burst running, assert res low mid-HIGH → gen_out=0 asynchronously. All registers read 0 after release; START with zeroed config sets cfg_err.
6. Read each address BASE_ADDR+0..+6 and BASE_ADDR+7 → written values returned one cycle after addr, CTRL and +7 read 0, STATUS writes have no effect.
